// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: recomplementer FSM states, complement mode
// encodings and the default operand width.
package arith_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic MODE_ONES = 1'b0;
  localparam logic MODE_TWOS = 1'b1;

  localparam int OPW = 11;
endpackage

// File: rtl/serial_comp_bit.sv
// Per-bit complement cell. Positive operands pass through unchanged.
// Ones' mode inverts every bit. Two's mode copies bits up to and including
// the first 1 and inverts every bit after it.
module serial_comp_bit
  import arith_pkg::*;
(
  input  logic b,
  input  logic sign,
  input  logic mode,
  input  logic seen_one,
  output logic r,
  output logic seen_one_next
);

  // Select the result bit and carry the seen-one state forward.
  always_comb begin
    r = b;
    if (sign) begin
      if (mode == MODE_TWOS) r = seen_one ? ~b : b;
      else                   r = ~b;
    end
    seen_one_next = seen_one | b;
  end

endmodule

// File: rtl/serial_recomp.sv
// Bit-serial recomplementer. It converts a ones'- or two's-complement operand
// into sign plus magnitude, handling one magnitude bit per clock, LSB first.
module serial_recomp
  import arith_pkg::*;
#(
  parameter int W  = OPW,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sign,
  output logic [W-2:0] out_mag,
  output logic         out_negzero,
  output logic         out_ovf
);

  state_t         state, nstate;
  logic [W-2:0]   sh, acc, acc_nx;
  logic [CW-1:0]  cnt;
  logic           sign_q, mode_q, seen_one, all_one;
  logic           r, seen_nx, last;

  serial_comp_bit u_bit (
    .b             (sh[0]),
    .sign          (sign_q),
    .mode          (mode_q),
    .seen_one      (seen_one),
    .r             (r),
    .seen_one_next (seen_nx)
  );

  assign last      = (cnt == CW'(W-2));
  assign acc_nx    = {r, acc[W-2:1]};
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (in_valid)  nstate = SHIFT;
      SHIFT:   if (last)      nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default:                nstate = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // Capture, serial shift and result publication. The result is built in acc
  // so that out_mag keeps the previous result until the new one is complete.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh          <= '0;
      acc         <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      mode_q      <= 1'b0;
      seen_one    <= 1'b0;
      all_one     <= 1'b0;
      out_sign    <= 1'b0;
      out_mag     <= '0;
      out_negzero <= 1'b0;
      out_ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sh       <= in_data[W-2:0];
          sign_q   <= in_data[W-1];
          mode_q   <= in_mode;
          cnt      <= '0;
          seen_one <= 1'b0;
          all_one  <= 1'b1;
        end
        SHIFT: begin
          sh       <= {1'b0, sh[W-2:1]};
          acc      <= acc_nx;
          cnt      <= cnt + CW'(1);
          seen_one <= seen_nx;
          all_one  <= all_one & sh[0];
          if (last) begin
            out_sign    <= sign_q;
            out_mag     <= acc_nx;
            out_negzero <= (mode_q == MODE_ONES) & sign_q & all_one & sh[0];
            out_ovf     <= (mode_q == MODE_TWOS) & sign_q & ~seen_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
